ram_access_ctrl: RTL
====================

// Module: ram_access_ctrl
// PURPOSE
//  Initiator-side controller for the single-port 512x32 data RAM. It accepts
//  read or write burst requests from the CPU datapath and sequences the RAM's
//  Read/Write/address/DataIn pins. It returns read data with the RAM's 1-cycle
//  registered latency. Sits between the MAR/MDR datapath logic and the RAM.
// PARAMETERS
//  ADDR_W  9   RAM word-address width (512 words)
//  DATA_W  32  data word width
//  LEN_W   3   burst length field width; burst = req_len+1 beats (1..8)
// PORTS
//  clock          in   1       system clock, all logic on posedge
//  clear          in   1       synchronous, active-high reset
//  req_valid      in   1       request present
//  req_ready      out  1       controller can accept request (IDLE only)
//  req_write      in   1       1=write burst, 0=read burst
//  req_addr       in   ADDR_W  first word address
//  req_len        in   LEN_W   beats minus one
//  wr_valid       in   1       write beat data present
//  wr_ready       out  1       write beat accepted this cycle
//  wr_data        in   DATA_W  write beat data
//  rd_valid       out  1       rd_data valid this cycle (no backpressure)
//  rd_data        out  DATA_W  read beat data (= mem_dout)
//  done           out  1       1-cycle pulse with final beat of a burst
//  mem_read       out  1       to RAM Read
//  mem_write      out  1       to RAM Write
//  mem_addr       out  ADDR_W  to RAM address
//  mem_din        out  DATA_W  to RAM DataIn
//  mem_dout       in   DATA_W  from RAM DataOut (registered in RAM)
// BEHAVIOUR
//  - Reset (clear=1 at posedge): state=IDLE; mem_read, mem_write, rd_valid,
//    done, wr_ready = 0; mem_addr, mem_din, beat counter = 0. RAM contents are
//    untouched. Any in-flight read is discarded: rd_valid stays 0 the next cycle.
//  - mem_read, mem_write, mem_addr, mem_din, rd_valid, done are registered.
//    req_ready and wr_ready are decoded from state. rd_data wires mem_dout.
//  - States: IDLE, WRITE, READ, DRAIN.
//  - IDLE: req_ready=1. On req_valid, latch addr, len, and dir at the edge.
//    Go to WRITE or READ.
//  - WRITE: wr_ready=1. On a wr_valid&wr_ready edge, the next cycle drives
//    mem_write=1, mem_addr=cur addr, mem_din=wr_data. The address then
//    increments. Gaps in wr_valid give mem_write=0 cycles and the burst holds.
//    done pulses in the same cycle as the final mem_write. The state returns
//    to IDLE at the edge that accepts the final beat.
//  - READ: issue one mem_read per cycle with no gaps, so mem_read=1 for len+1
//    consecutive cycles with incrementing mem_addr. rd_valid for beat i is
//    asserted exactly 1 cycle after beat i's mem_read cycle. After the final
//    issue, go to DRAIN for 1 cycle, in which rd_valid=1, done=1, then IDLE.
//  - Latency: a read accepted at edge a has its first mem_read in cycle a+1
//    and its first rd_valid in cycle a+2.
//  - Address arithmetic is mod 2^ADDR_W: 511 increments to 0. No error flag.
//  - mem_read and mem_write are never both 1 in the same cycle.
//  - Ordering: a write committed at edge k is visible to a read accepted at
//    edge >= k.
//  - req_valid outside IDLE is ignored (req_ready=0). wr_valid outside WRITE
//    is ignored.
//  - clear mid-burst takes priority over all events. The remaining beats are
//    dropped and done is not pulsed.
// STRUCTURE
//  - Shared package: state enum localparams (IDLE/WRITE/READ/DRAIN), the
//    ADDR_W/DATA_W defaults, and the RAM depth constant.
//  - One sub-module: ram_beat_counter (loadable down-counter for remaining
//    beats plus wrapping address incrementer). The FSM stays in the top.
// TESTING
//  1. Single write: addr=0x010, len=0, wr_data=0xDEADBEEF -> one mem_write
//     cycle with mem_addr=0x010. done in that cycle. req_ready=1 the next cycle.
//  2. Single read of 0x010 after test 1 -> mem_read in cycle a+1.
//     rd_valid=1 with rd_data=0xDEADBEEF in cycle a+2, done in the same cycle.
//  3. Read burst: addr=0x1FE, len=3 -> mem_addr sequence 1FE,1FF,000,001 on
//     4 consecutive cycles. 4 consecutive rd_valid. done on the 4th.
//  4. Write burst len=2 with wr_valid low for 2 cycles between beats 1 and 2
//     -> exactly 3 mem_write pulses, addresses contiguous, done with the 3rd.
//  5. clear asserted on the 2nd cycle of a len=7 read -> next cycle all mem_*,
//     rd_valid, done = 0 and req_ready=1. Re-reading earlier writes returns
//     the unchanged data.
//  6. Back-to-back: write 0x55 to addr 5, then a read of addr 5 accepted on
//     the first possible edge -> rd_data=0x00000055, and mem_read/mem_write
//     are never high together.

Source files
------------

// File: rtl/ram_access_ctrl_pkg.sv
// Shared types and constants for the data-RAM access controller.
package ram_access_ctrl_pkg;

  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned LEN_W     = 3;
  localparam int unsigned RAM_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Request as captured from the CPU side at the accepting edge.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } req_t;

  // Word-address increment; wraps 511 -> 0.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return ADDR_W'(a + 1'b1);
  endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// CPU request/beat channels plus the RAM pin bundle seen by the controller.
interface ram_access_ctrl_if;
  import ram_access_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  // Controller side.
  modport slave (
    input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, mem_dout,
    output req_ready, wr_ready, rd_valid, rd_data, done,
           mem_read, mem_write, mem_addr, mem_din
  );

  // Datapath and RAM side.
  modport master (
    output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, mem_dout,
    input  req_ready, wr_ready, rd_valid, rd_data, done,
           mem_read, mem_write, mem_addr, mem_din
  );

endinterface

// File: rtl/ram_beat_counter.sv
// Remaining-beat down-counter and wrapping word-address register for a burst.
module ram_beat_counter
  import ram_access_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] addr,
  output logic              last_c
);

  logic [LEN_W-1:0] remaining;

  // Load on request accept, advance one word per issued beat.
  always_ff @(posedge clock) begin
    if (clear) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_len;
    end else if (step) begin
      addr <= addr_inc(addr);
      if (remaining != '0) remaining <= LEN_W'(remaining - 1'b1);
    end
  end

  assign last_c = (remaining == '0);

endmodule

// File: rtl/ram_access_ctrl.sv
// Burst sequencer driving the single-port 512x32 data RAM pins.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  ram_access_ctrl_if.slave  bus
);

  state_e            state_q, state_d;
  req_t              req;
  logic              mem_read_d, mem_write_d, rd_valid_d, done_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_din_d;
  logic              cnt_load, cnt_step, cnt_last_c;
  logic [ADDR_W-1:0] cnt_load_addr, cnt_addr;

  assign req.write = bus.req_write;
  assign req.addr  = bus.req_addr;
  assign req.len   = bus.req_len;

  // Handshake readies decode straight from state; read data is the RAM's own register.
  assign bus.req_ready = (state_q == IDLE);
  assign bus.wr_ready  = (state_q == WRITE);
  assign bus.rd_data   = bus.mem_dout;

  ram_beat_counter u_beat_counter (
    .clock     (clock),
    .clear     (clear),
    .load      (cnt_load),
    .step      (cnt_step),
    .load_addr (cnt_load_addr),
    .load_len  (req.len),
    .addr      (cnt_addr),
    .last_c    (cnt_last_c)
  );

  // Next state and next values of the registered RAM/response outputs.
  always_comb begin
    state_d       = state_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_addr_d    = bus.mem_addr;
    mem_din_d     = bus.mem_din;
    rd_valid_d    = bus.mem_read;
    done_d        = 1'b0;
    cnt_load      = 1'b0;
    cnt_step      = 1'b0;
    cnt_load_addr = req.addr;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          cnt_load = 1'b1;
          if (req.write) begin
            state_d = WRITE;
          end else begin
            // First read issues on the accepting edge; counter tracks the next word.
            state_d       = READ;
            mem_read_d    = 1'b1;
            mem_addr_d    = req.addr;
            cnt_load_addr = addr_inc(req.addr);
          end
        end
      end
      WRITE: begin
        if (bus.wr_valid) begin
          mem_write_d = 1'b1;
          mem_addr_d  = cnt_addr;
          mem_din_d   = bus.wr_data;
          cnt_step    = 1'b1;
          if (cnt_last_c) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      READ: begin
        if (cnt_last_c) begin
          done_d  = 1'b1;
          state_d = DRAIN;
        end else begin
          mem_read_d = 1'b1;
          mem_addr_d = cnt_addr;
          cnt_step   = 1'b1;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; clear discards any burst in flight.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q       <= IDLE;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_din   <= '0;
      bus.rd_valid  <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus.mem_read  <= mem_read_d;
      bus.mem_write <= mem_write_d;
      bus.mem_addr  <= mem_addr_d;
      bus.mem_din   <= mem_din_d;
      bus.rd_valid  <= rd_valid_d;
      bus.done      <= done_d;
    end
  end

endmodule
